pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the single-cycle core: successor to the fixed 10-bit PC. Each cycle it selects the next fetch address from sequential advance, absolute jump (LUT-resolved target), signed relative branch, or call/return through an internal return-address stack. It also supports a stall hold. It raises a sticky `done` on halt, on run-off-end, or on a stack fault. It sits between control/LUT and `instr_ROM`, driving `prog_ctr`.

---
 rtl/pc_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the single-cycle core.
// Each cycle it picks the next fetch address: sequential advance, absolute jump,
// signed relative branch, or call/return through a small return-address stack.
// It supports a stall hold and sets a sticky done flag on halt, on run-off-end
// or on a stack fault.
//
// Optional feature macro: PC_SEQ_CALL_STACK_EN builds the return stack and
// enables call_en/ret_en/fault. Without it, call_en/ret_en are ignored, fault
// is tied to 0, stack_empty to 1 and stack_full to 0.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   stall       hold all state this cycle (drops any request)
//   halt        current instruction is halt
//   jmp_en      absolute jump to absaddress
//   absaddress  absolute target (jump/call)
//   rel_en      relative branch taken
//   rel_off     signed two's-complement branch offset
//   call_en     push PC+1, jump to absaddress
//   ret_en      pop return address into PC
//   prog_ctr    current fetch address (registered)
//   done        sticky program-finished flag
//   fault       sticky stack overflow/underflow flag
//   stack_empty stack pointer == 0
//   stack_full  stack pointer == STACK_D
module pc_sequencer #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned PROG_LEN = 1024,
  parameter int unsigned OFF_W    = 8,
  parameter int unsigned STACK_D  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             jmp_en,
  input  logic [PC_W-1:0]  absaddress,
  input  logic             rel_en,
  input  logic [OFF_W-1:0] rel_off,
  input  logic             call_en,
  input  logic             ret_en,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             done,
  output logic             fault,
  output logic             stack_empty,
  output logic             stack_full
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  typedef enum logic {ST_RUN, ST_HALTED} state_e;

  state_e                  state_q, state_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic                    done_q, done_d;
  logic [PC_W-1:0]         pc_inc;
  logic [PC_W-1:0]         pc_rel;
  logic signed [PC_W-1:0]  off_sext;

  // Sequential and relative successors; both wrap modulo 2^PC_W.
  assign pc_inc   = pc_q + PC_W'(1);
  assign off_sext = PC_W'($signed(rel_off));
  assign pc_rel   = pc_q + $unsigned(off_sext);

`ifdef PC_SEQ_CALL_STACK_EN
  localparam int unsigned SP_W  = $clog2(STACK_D + 1);
  localparam int unsigned IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  logic [PC_W-1:0]  stack_q [STACK_D];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             push;
  logic             fault_q, fault_d;
  logic             empty_q, full_q;

  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SP_W'(1));
`endif

  // Next-state / next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
`ifdef PC_SEQ_CALL_STACK_EN
    sp_d    = sp_q;
    push    = 1'b0;
    fault_d = fault_q;
`endif
    if (state_q == ST_RUN && !stall) begin
      if (halt) begin
        state_d = ST_HALTED;
        done_d  = 1'b1;
      end
`ifdef PC_SEQ_CALL_STACK_EN
      else if (ret_en) begin
        if (sp_q == SP_W'(0)) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          sp_d = sp_q - SP_W'(1);
          pc_d = stack_q[rd_idx];
        end
      end
      else if (call_en) begin
        if (sp_q == SP_W'(STACK_D)) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + SP_W'(1);
          pc_d = absaddress;
        end
      end
`endif
      else if (jmp_en) begin
        pc_d = absaddress;
      end
      else if (rel_en) begin
        pc_d = pc_rel;
      end
      else if (pc_q == LAST_PC) begin
        // Running off the end halts in place instead of wrapping to 0.
        state_d = ST_HALTED;
        done_d  = 1'b1;
      end
      else begin
        pc_d = pc_inc;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

`ifdef PC_SEQ_CALL_STACK_EN
  // Stack pointer and registered stack flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      fault_q <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      fault_q <= fault_d;
      empty_q <= (sp_d == SP_W'(0));
      full_q  <= (sp_d == SP_W'(STACK_D));
    end
  end

  // Stack storage has no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      stack_q[wr_idx] <= pc_inc;
    end
  end

  assign fault       = fault_q;
  assign stack_empty = empty_q;
  assign stack_full  = full_q;
`else
  logic unused_stack_inputs;
  assign unused_stack_inputs = call_en ^ ret_en;

  assign fault       = 1'b0;
  assign stack_empty = 1'b1;
  assign stack_full  = 1'b0;
`endif

  assign prog_ctr = pc_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (PC_W=10, PROG_LEN=1024, STACK_D=4).
// Vectors hold {controls, operands, expected PC and flags}; each one is driven
// on the falling edge, its expectation queued, and checked 1 ns after the next
// rising edge. Expectations adapt to whether the call stack is built.
module tb_pc_sequencer;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned OFF_W = 8;

`ifdef PC_SEQ_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  // Control bits: {reset, stall, halt, jmp, rel, call, ret}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_RST  = 7'b1000000;
  localparam logic [6:0] C_STL  = 7'b0100000;
  localparam logic [6:0] C_HLT  = 7'b0010000;
  localparam logic [6:0] C_JMP  = 7'b0001000;
  localparam logic [6:0] C_REL  = 7'b0000100;
  localparam logic [6:0] C_CAL  = 7'b0000010;
  localparam logic [6:0] C_RET  = 7'b0000001;

  // Flag bits: {done, fault, stack_empty, stack_full}
  localparam logic [3:0] F_RUN = 4'b0010;

  typedef struct {
    logic [6:0]       ctl;
    logic [PC_W-1:0]  abs;
    logic [OFF_W-1:0] off;
    logic [PC_W-1:0]  pc;
    logic [3:0]       flg;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset, stall, halt, jmp_en, rel_en, call_en, ret_en;
  logic [PC_W-1:0]  absaddress;
  logic [OFF_W-1:0] rel_off;
  logic [PC_W-1:0]  prog_ctr;
  logic             done, fault, stack_empty, stack_full;

  vec_t  tbl[$];
  string tags[$];
  vec_t  exp_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  pc_sequencer #(
    .PC_W(PC_W), .PROG_LEN(1024), .OFF_W(OFF_W), .STACK_D(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .jmp_en(jmp_en), .absaddress(absaddress), .rel_en(rel_en), .rel_off(rel_off),
    .call_en(call_en), .ret_en(ret_en), .prog_ctr(prog_ctr), .done(done),
    .fault(fault), .stack_empty(stack_empty), .stack_full(stack_full)
  );

  always #5 clk = ~clk;

  function automatic int si(input int a, input int b);
    return STK ? a : b;
  endfunction

  function automatic logic [3:0] sf(input logic [3:0] a, input logic [3:0] b);
    return STK ? a : b;
  endfunction

  task automatic add(input string tag, input logic [6:0] c, input int abs, input int off,
                     input int pc, input logic [3:0] f);
    vec_t v;
    v.ctl = c;
    v.abs = PC_W'(abs);
    v.off = OFF_W'(off);
    v.pc  = PC_W'(pc);
    v.flg = f;
    tbl.push_back(v);
    tags.push_back(tag);
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t       e;
    logic [3:0] got;
    @(negedge clk);
    {reset, stall, halt, jmp_en, rel_en, call_en, ret_en} = v.ctl;
    absaddress = v.abs;
    rel_off    = v.off;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = {done, fault, stack_empty, stack_full};
    n_vec++;
    if (prog_ctr !== e.pc || got !== e.flg) begin
      n_miss++;
      $display("FAIL %s: prog_ctr=%0d flags(done,fault,empty,full)=%b, required prog_ctr=%0d flags=%b",
               tag, prog_ctr, got, e.pc, e.flg);
    end
  endtask

  initial begin
    {reset, stall, halt, jmp_en, rel_en, call_en, ret_en} = C_NONE;
    absaddress = '0;
    rel_off    = '0;

    // Reset then sequential advance.
    add("reset", C_RST, 0, 0, 0, F_RUN);
    for (int i = 1; i <= 5; i++) add("seq", C_NONE, 0, 0, i, F_RUN);

    // Relative branches, including wrap and extreme offsets.
    add("jmp20",    C_JMP, 20,   0,     20,   F_RUN);
    add("rel_neg",  C_REL, 0,    8'hFB, 15,   F_RUN);
    add("jmp1020",  C_JMP, 1020, 0,     1020, F_RUN);
    add("rel_wrap", C_REL, 0,    8,     4,    F_RUN);
    add("rel_max",  C_REL, 0,    8'h7F, 131,  F_RUN);
    add("rel_min",  C_REL, 0,    8'h80, 3,    F_RUN);

    // Call / return (jmp_en also raised so the no-stack build lands on the same target).
    add("jmp7",   C_JMP,         7,   0, 7,            F_RUN);
    add("call",   C_CAL | C_JMP, 100, 0, 100,          sf(4'b0000, F_RUN));
    add("seq101", C_NONE,        0,   0, 101,          sf(4'b0000, F_RUN));
    add("ret",    C_RET,         0,   0, si(8, 102),   F_RUN);

    // Fill the stack, then overflow.
    add("jmp200", C_JMP, 200, 0, 200, F_RUN);
    for (int i = 0; i < 4; i++)
      add("fill", C_CAL | C_JMP, 300 + i, 0, 300 + i, sf((i == 3) ? 4'b0001 : 4'b0000, F_RUN));
    add("ovf",        C_CAL | C_JMP, 400, 0, si(303, 400), sf(4'b1101, F_RUN));
    add("ovf_frozen", C_JMP,         5,   0, si(303, 5),   sf(4'b1101, F_RUN));
    add("rst_stall",  C_RST | C_STL, 0,   0, 0,            F_RUN);

    // Underflow.
    add("unf",        C_RET,  0, 0, si(0, 1), sf(4'b1110, F_RUN));
    add("unf_frozen", C_NONE, 0, 0, si(0, 2), sf(4'b1110, F_RUN));
    add("rst2",       C_RST,  0, 0, 0,        F_RUN);

    // LIFO order, then ret beating a simultaneous call.
    add("jmp50",    C_JMP,                 50, 0, 50,           F_RUN);
    add("call60",   C_CAL | C_JMP,         60, 0, 60,           sf(4'b0000, F_RUN));
    add("call70",   C_CAL | C_JMP,         70, 0, 70,           sf(4'b0000, F_RUN));
    add("ret61",    C_RET,                 0,  0, si(61, 71),   sf(4'b0000, F_RUN));
    add("ret51",    C_RET,                 0,  0, si(51, 72),   F_RUN);
    add("call80",   C_CAL | C_JMP,         80, 0, 80,           sf(4'b0000, F_RUN));
    add("ret_call", C_RET | C_CAL | C_JMP, 90, 0, si(52, 90),   F_RUN);

    // Stall drops a jump; stall overrides halt; halt freezes.
    add("jmp9", C_JMP, 9, 0, 9, F_RUN);
    for (int i = 0; i < 3; i++) add("stall_jmp", C_STL | C_JMP, 500, 0, 9, F_RUN);
    for (int i = 10; i <= 12; i++) add("seq", C_NONE, 0, 0, i, F_RUN);
    add("stall_halt", C_STL | C_HLT, 0, 0, 12, F_RUN);
    add("halt",       C_HLT,         0, 0, 12, 4'b1010);
    for (int i = 0; i < 10; i++)
      add("halted_hold", C_JMP | C_REL | C_CAL | C_RET, 600, 3, 12, 4'b1010);
    add("rst3", C_RST, 0, 0, 0, F_RUN);

    // Run-off-end at PROG_LEN-1.
    add("jmp1021", C_JMP,  1021, 0, 1021, F_RUN);
    add("seq1022", C_NONE, 0,    0, 1022, F_RUN);
    add("seq1023", C_NONE, 0,    0, 1023, F_RUN);
    add("end",     C_NONE, 0,    0, 1023, 4'b1010);
    add("end_hold", C_NONE, 0,   0, 1023, 4'b1010);
    add("rst4",    C_RST,  0,    0, 0,    F_RUN);
    add("seq1",    C_NONE, 0,    0, 1,    F_RUN);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], tags[i]);

    // Hand-written: reset asserted while halted with stall held, then resume.
    apply(tbl[0], "pre_halt");
    begin
      vec_t v;
      v.ctl = C_HLT; v.abs = '0; v.off = '0; v.pc = PC_W'(0); v.flg = 4'b1010;
      apply(v, "halt_at0");
      v.ctl = C_RST | C_STL; v.flg = F_RUN;
      apply(v, "rst_in_halt");
      v.ctl = C_STL;
      apply(v, "stall_after_rst");
      v.ctl = C_NONE; v.pc = PC_W'(1);
      apply(v, "resume");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
